// File: rtl/tagged_fifo_dispatch.sv
// Steers one tagged input stream into NUM_FIFOS independent circular FIFOs with per-channel pops.
// Optional saturating dropped-push counter when DISPATCH_DROP_CNT_EN is defined.
module tagged_fifo_dispatch #(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [TAGWIDTH-1:0]        tag,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       push_rdy,
  input  logic [NUM_FIFOS-1:0]       pop,
  output logic [NUM_FIFOS*WIDTH-1:0] data_out,
  output logic [NUM_FIFOS-1:0]       vld,
  output logic [NUM_FIFOS-1:0]       full
`ifdef DISPATCH_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LP_PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] LP_CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0]     r_mem    [NUM_FIFOS][DEPTH];
  logic [PW-1:0]        r_wr_ptr [NUM_FIFOS];
  logic [PW-1:0]        r_rd_ptr [NUM_FIFOS];
  logic [CW-1:0]        r_cnt    [NUM_FIFOS];
  logic [NUM_FIFOS-1:0] w_push_ch;
  logic [NUM_FIFOS-1:0] w_pop_ch;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LP_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // An out-of-range tag matches no channel, so push_rdy stays low for it.
  always_comb begin
    push_rdy  = 1'b0;
    w_push_ch = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      if (tag == TAGWIDTH'(k)) begin
        push_rdy     = !full[k];
        w_push_ch[k] = push && !full[k];
      end
    end
  end

  assign w_pop_ch = pop & vld;

  for (genvar k = 0; k < NUM_FIFOS; k++) begin : g_ch
    assign vld[k]                       = (r_cnt[k] != '0);
    assign full[k]                      = (r_cnt[k] == LP_CNT_FULL);
    assign data_out[k*WIDTH +: WIDTH]   = r_mem[k][r_rd_ptr[k]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_FIFOS; k++) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
        r_cnt[k]    <= '0;
        for (int e = 0; e < DEPTH; e++) r_mem[k][e] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_FIFOS; k++) begin
        if (w_push_ch[k]) begin
          r_mem[k][r_wr_ptr[k]] <= data_in;
          r_wr_ptr[k]           <= ptr_inc(r_wr_ptr[k]);
        end
        if (w_pop_ch[k]) r_rd_ptr[k] <= ptr_inc(r_rd_ptr[k]);
        case ({w_push_ch[k], w_pop_ch[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + 1'b1;
          2'b01:   r_cnt[k] <= r_cnt[k] - 1'b1;
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

`ifdef DISPATCH_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_drop   = push && !push_rdy;
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
  end
`endif

endmodule

// File: tb/tb_tagged_fifo_dispatch.sv
// Randomized and directed bench for tagged_fifo_dispatch against a queue-based reference model.
// Two instances: 4 channels x depth 4, and 3 channels x depth 3 (exercises wrap and out-of-range tag).
module tb_tagged_fifo_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [1:0]  tag;
  logic [7:0]  din;
  logic [3:0]  pop;
  logic        prA, prB;
  logic [31:0] doA;
  logic [23:0] doB;
  logic [3:0]  vA, fA;
  logic [2:0]  vB, fB;
`ifdef DISPATCH_DROP_CNT_EN
  logic [7:0]  dcA, dcB;
`endif

  always #5 clk = ~clk;

  tagged_fifo_dispatch #(.NUM_FIFOS(4), .WIDTH(8), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .push(push), .tag(tag), .data_in(din), .push_rdy(prA),
    .pop(pop), .data_out(doA), .vld(vA), .full(fA)
`ifdef DISPATCH_DROP_CNT_EN
    , .drop_cnt(dcA)
`endif
  );

  tagged_fifo_dispatch #(.NUM_FIFOS(3), .WIDTH(8), .DEPTH(3)) u_dut_b (
    .clk(clk), .rst(rst), .push(push), .tag(tag), .data_in(din), .push_rdy(prB),
    .pop(pop[2:0]), .data_out(doB), .vld(vB), .full(fB)
`ifdef DISPATCH_DROP_CNT_EN
    , .drop_cnt(dcB)
`endif
  );

  logic [7:0] mq [2][4][$];
  int nf [2] = '{4, 3};
  int dp [2] = '{4, 3};
  int mdrop [2];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic exp_rdy(input int i);
    return (int'(tag) < nf[i]) && (mq[i][int'(tag)].size() < dp[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) mq[i][k].delete();
      mdrop[i] = 0;
    end
  endtask

  // Called with inputs stable before the edge: decisions use pre-edge occupancy.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic acc;
      acc = push && exp_rdy(i);
      for (int k = 0; k < nf[i]; k++)
        if (pop[k] && mq[i][k].size() > 0) void'(mq[i][k].pop_front());
      if (acc) mq[i][int'(tag)].push_back(din);
      else if (push && mdrop[i] < 255) mdrop[i]++;
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      logic [3:0]  v, f, ev, ef;
      logic [31:0] d;
      string       s;
      s  = (i == 0) ? "A" : "B";
      v  = (i == 0) ? vA : {1'b0, vB};
      f  = (i == 0) ? fA : {1'b0, fB};
      d  = (i == 0) ? doA : {8'h00, doB};
      ev = '0;
      ef = '0;
      for (int k = 0; k < nf[i]; k++) begin
        ev[k] = mq[i][k].size() > 0;
        ef[k] = mq[i][k].size() == dp[i];
      end
      chk({"vld", s}, {28'd0, v}, {28'd0, ev});
      chk({"full", s}, {28'd0, f}, {28'd0, ef});
      for (int k = 0; k < nf[i]; k++)
        if (mq[i][k].size() > 0)
          chk($sformatf("data%s%0d", s, k), {24'd0, d[k*8 +: 8]}, {24'd0, mq[i][k][0]});
    end
`ifdef DISPATCH_DROP_CNT_EN
    chk("dropA", {24'd0, dcA}, mdrop[0]);
    chk("dropB", {24'd0, dcB}, mdrop[1]);
`endif
  endtask

  task automatic cyc(input logic p, input logic [1:0] t, input logic [7:0] d, input logic [3:0] pp);
    push = p;
    tag  = t;
    din  = d;
    pop  = pp;
    #1;
    chk("rdyA", {31'd0, prA}, {31'd0, exp_rdy(0)});
    chk("rdyB", {31'd0, prB}, {31'd0, exp_rdy(1)});
    model_edge();
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_vA"}, {28'd0, vA}, 32'd0);
    chk({name, "_fA"}, {28'd0, fA}, 32'd0);
    chk({name, "_dA"}, doA, 32'd0);
    chk({name, "_vB"}, {29'd0, vB}, 32'd0);
    chk({name, "_fB"}, {29'd0, fB}, 32'd0);
    chk({name, "_dB"}, {8'd0, doB}, 32'd0);
`ifdef DISPATCH_DROP_CNT_EN
    chk({name, "_dcA"}, {24'd0, dcA}, 32'd0);
`endif
  endtask

  initial begin
    push = 1'b0; tag = '0; din = '0; pop = '0; rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill channel 2, then probe readiness for tag 2 and tag 0.
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd2, 8'h11 * 8'(i + 1), 4'b0000);
    cyc(1'b0, 2'd2, 8'h00, 4'b0000);
    cyc(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("fill_head", {24'd0, doA[23:16]}, 32'h11);

    // Alternate pop and push across the pointer wrap, then drain.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'd2, 8'h00, 4'b0100);
      cyc(1'b1, 2'd2, 8'h55 + 8'(i), 4'b0000);
    end
    repeat (4) cyc(1'b0, 2'd0, 8'h00, 4'b0100);

    // Overflow on channel 1, including sustained drops.
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd1, 8'hC0 + 8'(i), 4'b0000);
    repeat (3) cyc(1'b1, 2'd1, 8'hEE, 4'b0000);
    repeat (300) cyc(1'b1, 2'd1, 8'hEF, 4'b0000);

    // Simultaneous push/pop on a full channel and on an empty channel.
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, 8'hA0 + 8'(i), 4'b0000);
    cyc(1'b1, 2'd0, 8'hBB, 4'b0001);
    cyc(1'b1, 2'd3, 8'h3C, 4'b1000);

    // Parallel drain of two words per channel.
    repeat (4) cyc(1'b0, 2'd0, 8'h00, 4'b1111);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++) cyc(1'b1, 2'(k), 8'(16 * k + j + 1), 4'b0000);
    repeat (2) cyc(1'b0, 2'd0, 8'h00, 4'b1111);

    // Randomized traffic.
    repeat (600) begin
      logic [3:0] rp;
      for (int k = 0; k < 4; k++) rp[k] = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 9) < 8, 2'($urandom), 8'($urandom), rp);
    end

    // Reset asserted between edges, released with a push pending.
    push = 1'b0; pop = '0;
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 2'd0, 8'hA5, 4'b0000);
    chk("post_rst_data", {24'd0, doA[7:0]}, 32'hA5);
    chk("post_rst_vld", {28'd0, vA}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tagged_fifo_dispatch.md
# tagged_fifo_dispatch

- Write-side counterpart of the arbitrated FIFO bank: accepts one tagged input stream and steers each word into one of NUM_FIFOS per-channel circular FIFOs.
- Downstream consumers drain the FIFOs independently, each with its own pop.
- Sits between a single producer and a set of per-channel consumers, for example per-channel arbiters or scoreboards.
- Reports per-channel occupancy flags and, optionally, a count of dropped pushes.

## Interface

Parameters:
- NUM_FIFOS, 4, number of output channels (≥2)
- WIDTH, 8, data word width
- DEPTH, 4, entries per channel FIFO (≥2; power of two not required)
- TAGWIDTH, $clog2(NUM_FIFOS), width of destination tag

Ports:
- clk  input  1  single clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- push  input  1  producer offers data_in this cycle
- tag  input  TAGWIDTH  destination channel of data_in
- data_in  input  WIDTH  word to enqueue
- push_rdy  output  1  combinational: tag < NUM_FIFOS and !full[tag]
- pop  input  NUM_FIFOS  per-channel dequeue request
- data_out  output  NUM_FIFOS*WIDTH  flat; channel k head at [(k+1)*WIDTH-1:k*WIDTH]
- vld  output  NUM_FIFOS  channel k non-empty (= ~empty[k])
- full  output  NUM_FIFOS  channel k holds DEPTH entries
- drop_cnt  output  8  saturating dropped-push count (present only with DISPATCH_DROP_CNT_EN)

## Operation

- Each channel has a write pointer wr_ptr[k], a read pointer rd_ptr[k] (each $clog2(DEPTH) bits) and a count cnt[k] ($clog2(DEPTH+1) bits).
- Pointers advance modulo DEPTH: after DEPTH-1 they wrap to 0.
- Accepted push: push && push_rdy. The word is written at wr_ptr[tag], which then advances, and cnt[tag] increments.
- Dropped push: push && !push_rdy. This happens when the target is full or the tag is out of range. No state changes except drop_cnt.
- Accepted pop: pop[k] && vld[k]. rd_ptr[k] advances and cnt[k] decrements. pop[k] on an empty channel is ignored.
- full[k] = (cnt[k] == DEPTH); vld[k] = (cnt[k] != 0).
- data_out for channel k is the storage word at rd_ptr[k] (first-word fall-through). When vld[k]=0, its contents are don't-care.
- Only one channel can be pushed per cycle. All channels can pop in the same cycle.
- Push and pop on the same channel in the same cycle:
  - both accepted: cnt unchanged, both pointers advance
  - channel empty: only the push is accepted
  - channel full: the push is dropped, because push_rdy never depends on pop; the pop proceeds
- There is no internal state machine beyond the per-channel counters. Channels are fully independent apart from the shared write port.

## Timing

- Reset (async assert, synchronous-edge release): all pointers and counts go to 0. Outputs after reset: vld=0, full=0, drop_cnt=0, data_out=0 (storage cleared).
- push_rdy is combinational from tag and state, with no dependency on push or pop.
- Latency: a word accepted at edge t appears on data_out and raises vld[tag] after edge t. It can be popped in cycle t+1.
- full[k] rises the cycle after the DEPTH-th accepted push. It falls the cycle after an accepted pop.
- Reset asserted mid-operation discards all stored words immediately. A push coincident with reset release is accepted normally on the first post-reset edge.

## Configuration

- DISPATCH_DROP_CNT_EN defined:
  - drop_cnt port exists
  - increments by 1 on each dropped push and saturates at 255
  - reset to 0
- DISPATCH_DROP_CNT_EN undefined:
  - port and counter are removed
  - dropped pushes are silently discarded
  - all other behaviour is identical

## Test plan

- Fill: NUM_FIFOS=4, DEPTH=4. Push 0x11,0x22,0x33,0x44 with tag=2, no pops → full=4'b0100 and vld=4'b0100 after the 4th edge; channel 2 data_out=0x11; push_rdy=0 for tag=2 and 1 for tag=0.
- Order and wrap: continue from fill, alternating pop[2] and push tag=2 of 0x55..0x58 → channel 2 drains 0x11..0x44 then 0x55..0x58 in order across pointer wrap. With DEPTH=3, pointers go 0,1,2,0.
- Overflow with DISPATCH_DROP_CNT_EN: channel 1 full, push tag=1 for 3 cycles → contents unchanged, drop_cnt=3. Sustained 300 drops → drop_cnt=255.
- Simultaneous: channel 0 full with pop[0]=1 and push tag=0 → push dropped, cnt[0]=3, full[0]=0. Channel 3 empty with push tag=3 and pop[3]=1 → vld[3]=1 next cycle, word retained.
- Parallel drain: all 4 channels hold 2 words; assert pop=4'b1111 for 2 cycles → vld=0 afterwards, and each channel's data_out follows its own order.
- Reset mid-stream: channels partially filled, assert rst between edges → vld=0, full=0, data_out=0 immediately; the first post-reset push with tag=0 and data 0xA5 appears at channel 0 one cycle later.
